// File: rtl/palette_lookup_pkg.sv
// Shared video definitions for the palette stage: widths, timing strobe
// bit positions, palette depth and the default grey-ramp palette.
package palette_lookup_pkg;

    localparam int RGB_W      = 12;
    localparam int IDX_W      = 8;
    localparam int PAL_DEPTH  = 256;

    localparam int SYNC_HSYNC = 0;
    localparam int SYNC_VSYNC = 1;
    localparam int SYNC_BLANK = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pal_state_t;

    // Grey ramp: every channel takes the top nibble of the index.
    function automatic logic [RGB_W-1:0] default_rgb(input logic [IDX_W-1:0] idx);
        return {3{idx[7:4]}};
    endfunction

endpackage

// File: rtl/palette_lookup_palette_ram.sv
// Synchronous RAM with one read/write port (read-before-write) and one
// independent read-only port. Only the output registers are reset.
module palette_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    a_addr,
    input  logic             a_we,
    input  logic [WIDTH-1:0] a_wdata,
    output logic [WIDTH-1:0] a_rdata,
    input  logic [AW-1:0]    b_addr,
    output logic [WIDTH-1:0] b_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Both ports sample the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= mem[a_addr];
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/palette_lookup.sv
// Colour-index to 12-bit RGB palette stage with CPU access and a
// self-loading default palette; timing strobes are delayed to match.
module palette_lookup
    import palette_lookup_pkg::*;
#(
    parameter int SYNC_W        = 3,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8:0]        pal_addr,
    input  logic [7:0]        pal_wrdata,
    input  logic              pal_write,
    output logic [7:0]        pal_rddata,
    output logic              init_busy,
    input  logic [IDX_W-1:0]  pix_index,
    input  logic [SYNC_W-1:0] sync_in,
    output logic [RGB_W-1:0]  rgb_out,
    output logic [SYNC_W-1:0] sync_out
);

    localparam logic [SYNC_W-1:0] SYNC_IDLE = SYNC_W'(1) << SYNC_BLANK;

    pal_state_t       state;
    pal_state_t       state_next;
    logic [IDX_W-1:0] init_cnt;
    logic [RGB_W-1:0] ramp;

    logic [IDX_W-1:0] port_addr;
    logic             lo_we;
    logic             hi_we;
    logic [7:0]       lo_wdata;
    logic [3:0]       hi_wdata;
    logic [7:0]       lo_cpu_rdata;
    logic [3:0]       hi_cpu_rdata;
    logic [7:0]       lo_pix_rdata;
    logic [3:0]       hi_pix_rdata;
    logic             rd_hi;
    logic [SYNC_W-1:0] sync_d1;

    assign ramp      = default_rgb(init_cnt);
    assign init_busy = (state == ST_INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_INIT && init_cnt == 8'hFF) begin
            state_next = ST_RUN;
        end
    end

    // The CPU port is borrowed by the ramp writer while INIT runs, which
    // is also what silently drops CPU writes during that window.
    always_comb begin
        port_addr = pal_addr[8:1];
        lo_we     = 1'b0;
        hi_we     = 1'b0;
        lo_wdata  = pal_wrdata;
        hi_wdata  = pal_wrdata[3:0];
        if (state == ST_INIT) begin
            port_addr = init_cnt;
            lo_we     = ~rst;
            hi_we     = ~rst;
            lo_wdata  = ramp[7:0];
            hi_wdata  = ramp[11:8];
        end else begin
            lo_we = pal_write & ~pal_addr[0] & ~rst;
            hi_we = pal_write &  pal_addr[0] & ~rst;
        end
    end

    palette_ram #(.WIDTH(8), .DEPTH(PAL_DEPTH)) u_lo_ram (
        .clk     (clk),
        .rst     (rst),
        .a_addr  (port_addr),
        .a_we    (lo_we),
        .a_wdata (lo_wdata),
        .a_rdata (lo_cpu_rdata),
        .b_addr  (pix_index),
        .b_rdata (lo_pix_rdata)
    );

    palette_ram #(.WIDTH(4), .DEPTH(PAL_DEPTH)) u_hi_ram (
        .clk     (clk),
        .rst     (rst),
        .a_addr  (port_addr),
        .a_we    (hi_we),
        .a_wdata (hi_wdata),
        .a_rdata (hi_cpu_rdata),
        .b_addr  (pix_index),
        .b_rdata (hi_pix_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_hi <= 1'b0;
        end else begin
            rd_hi <= pal_addr[0];
        end
    end

    assign pal_rddata = rd_hi ? {4'h0, hi_cpu_rdata} : lo_cpu_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_out  <= '0;
            sync_d1  <= SYNC_IDLE;
            sync_out <= SYNC_IDLE;
        end else begin
            rgb_out  <= (state == ST_INIT) ? '0 : {hi_pix_rdata, lo_pix_rdata};
            sync_d1  <= sync_in;
            sync_out <= sync_d1;
        end
    end

endmodule

// File: tb/tb_palette_lookup.sv
// Self-checking bench for palette_lookup: reset/INIT timing, directed
// palette cases, collisions and a randomized run against a palette model.
module tb_palette_lookup;

    logic        clk;
    logic        rst;
    logic [8:0]  pal_addr;
    logic [7:0]  pal_wrdata;
    logic        pal_write;
    logic [7:0]  pal_rddata;
    logic        init_busy;
    logic [7:0]  pix_index;
    logic [2:0]  sync_in;
    logic [11:0] rgb_out;
    logic [2:0]  sync_out;

    palette_lookup #(.SYNC_W(3), .INIT_ON_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .pal_addr   (pal_addr),
        .pal_wrdata (pal_wrdata),
        .pal_write  (pal_write),
        .pal_rddata (pal_rddata),
        .init_busy  (init_busy),
        .pix_index  (pix_index),
        .sync_in    (sync_in),
        .rgb_out    (rgb_out),
        .sync_out   (sync_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lo [256];
    logic [3:0] m_hi [256];

    typedef struct packed {
        logic [11:0] rgb;
        logic [2:0]  sync;
    } disp_t;
    disp_t exp_q[$];

    typedef struct packed {
        logic [7:0]  pix;
        logic [11:0] exp_rgb;
    } vec_t;
    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_ramp();
        for (int i = 0; i < 256; i++) begin
            m_hi[i] = 4'(i / 16);
            m_lo[i] = 8'((i / 16) * 17);
        end
    endfunction

    function automatic void model_write(input logic [8:0] a, input logic [7:0] d);
        if (a[0]) m_hi[a[8:1]] = d[3:0];
        else      m_lo[a[8:1]] = d;
    endfunction

    task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
        pal_addr   = a;
        pal_wrdata = d;
        pal_write  = 1'b1;
        step();
        pal_write  = 1'b0;
        model_write(a, d);
    endtask

    // One RUN-mode cycle checked against the palette model.
    task automatic run_cycle(input logic [7:0] pix, input logic [2:0] sy, input logic wr,
                             input logic [8:0] a, input logic [7:0] d);
        disp_t      e;
        logic [7:0] rd_e;
        e.rgb  = {m_hi[pix], m_lo[pix]};
        e.sync = sy;
        exp_q.push_back(e);
        rd_e = a[0] ? {4'h0, m_hi[a[8:1]]} : m_lo[a[8:1]];
        if (wr) model_write(a, d);
        pix_index  = pix;
        sync_in    = sy;
        pal_write  = wr;
        pal_addr   = a;
        pal_wrdata = d;
        step();
        check("rand_rddata", {8'h0, pal_rddata}, {8'h0, rd_e});
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("rand_rgb", {4'h0, rgb_out}, {4'h0, e.rgb});
            check("rand_sync", {13'h0, sync_out}, {13'h0, e.sync});
        end
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        while (init_busy && n < 600) begin
            step();
            n++;
        end
        check(name, 16'(n), 16'd256);
    endtask

    initial begin
        int          n;
        int          rgb_bad;
        int          sync_bad;
        logic [2:0]  sq[$];
        logic [2:0]  s;
        logic [7:0]  pix;
        logic [8:0]  a;
        logic [7:0]  exp_b;
        logic        wr;

        rst = 1'b1; pal_addr = '0; pal_wrdata = '0; pal_write = 1'b0;
        pix_index = '0; sync_in = '0;
        vecs[0] = '{8'hA7, 12'hAAA};
        vecs[1] = '{8'h00, 12'h000};
        vecs[2] = '{8'hFF, 12'hFFF};
        vecs[3] = '{8'h5A, 12'h555};
        vecs[4] = '{8'h10, 12'h111};
        vecs[5] = '{8'h0F, 12'h000};
        vecs[6] = '{8'h80, 12'h888};

        // Reset values
        step(); step();
        check("reset_rgb", {4'h0, rgb_out}, 16'h0000);
        check("reset_sync", {13'h0, sync_out}, 16'h0004);
        check("reset_rddata", {8'h0, pal_rddata}, 16'h0000);
        check("reset_busy", {15'h0, init_busy}, 16'h0001);

        // INIT: busy exactly 256 cycles, rgb zero, syncs still delayed by 2,
        // CPU write at cycle 10 dropped.
        rst = 1'b0;
        n = 0; rgb_bad = 0; sync_bad = 0;
        while (init_busy && n < 600) begin
            s = 3'($urandom_range(0, 7));
            sync_in   = s;
            pix_index = 8'($urandom_range(0, 255));
            sq.push_back(s);
            if (n == 10) begin
                pal_addr = 9'h000; pal_wrdata = 8'hFF; pal_write = 1'b1;
            end
            step();
            pal_write = 1'b0;
            n++;
            if (init_busy && rgb_out !== 12'h000) rgb_bad++;
            if (sq.size() >= 2) begin
                s = sq.pop_front();
                if (sync_out !== s) sync_bad++;
            end
        end
        check("init_cycles", 16'(n), 16'd256);
        check("init_rgb_zero", 16'(rgb_bad), 16'd0);
        check("init_sync_track", 16'(sync_bad), 16'd0);
        model_ramp();

        pal_addr = 9'h000; step();
        check("dropped_write_lo", {8'h0, pal_rddata}, 16'h0000);
        pal_addr = 9'h001; step();
        check("dropped_write_hi", {8'h0, pal_rddata}, 16'h0000);

        // Default ramp through the display path
        sync_in = 3'b000;
        for (int i = 0; i < 7; i++) begin
            pix_index = vecs[i].pix;
            step(); step();
            check("ramp_vec", {4'h0, rgb_out}, {4'h0, vecs[i].exp_rgb});
        end

        // CPU byte writes, odd-byte masking, read-during-write
        cpu_write(9'h014, 8'h5C);
        cpu_write(9'h015, 8'hF3);
        pix_index = 8'h0A;
        step(); step();
        check("written_rgb", {4'h0, rgb_out}, 16'h035C);
        pal_addr = 9'h015; step();
        check("odd_read_masked", {8'h0, pal_rddata}, 16'h0003);
        pal_addr = 9'h014; step();
        check("even_read", {8'h0, pal_rddata}, 16'h005C);
        pal_addr = 9'h014; pal_wrdata = 8'h77; pal_write = 1'b1;
        step();
        pal_write = 1'b0;
        model_write(9'h014, 8'h77);
        check("rd_wr_same_old", {8'h0, pal_rddata}, 16'h005C);
        step();
        check("rd_after_wr_new", {8'h0, pal_rddata}, 16'h0077);

        // Display collision: same-cycle write shows old, next pixel new
        pix_index = 8'h20; pal_addr = 9'h040; pal_wrdata = 8'h11; pal_write = 1'b1;
        step();
        pal_write = 1'b0;
        model_write(9'h040, 8'h11);
        step();
        check("collision_old", {4'h0, rgb_out}, 16'h0222);
        step();
        check("collision_new", {4'h0, rgb_out}, 16'h0211);

        // Randomized RUN traffic against the palette model
        exp_q.delete();
        for (int k = 0; k < 300; k++) begin
            a   = 9'($urandom_range(0, 511));
            pix = ($urandom_range(0, 3) == 0) ? a[8:1] : 8'($urandom_range(0, 255));
            wr  = ($urandom_range(0, 3) == 0);
            run_cycle(pix, 3'($urandom_range(0, 7)), wr, a, 8'($urandom_range(0, 255)));
        end

        // Reset at INIT cycle 100 restarts the ramp from entry 0
        rst = 1'b1; step();
        rst = 1'b0;
        pal_write = 1'b0;
        repeat (100) step();
        rst = 1'b1; step();
        check("restart_busy", {15'h0, init_busy}, 16'h0001);
        rst = 1'b0;
        count_init("restart_cycles");
        for (int i = 0; i < 512; i++) begin
            pal_addr = 9'(i);
            step();
            exp_b = (i % 2 == 1) ? 8'(i / 32) : 8'((i / 32) * 17);
            check("ramp_readback", {8'h0, pal_rddata}, {8'h0, exp_b});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
